// File: rtl/packed_lane_packer.sv
// Stream-to-word packer: gathers LANE_W-bit elements into a
// [LANES-1:0][LANE_W-1:0] word with lane mask and count.
module packed_lane_packer #(
  parameter int LANES  = 4,
  parameter int LANE_W = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANE_W-1:0]            in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*LANE_W-1:0]      out_data,
  output logic [LANES-1:0]             out_mask,
  output logic [$clog2(LANES+1)-1:0]   out_count
);

  localparam int IW = $clog2(LANES);
  localparam int CW = $clog2(LANES+1);
  localparam int DW = LANES*LANE_W;

  typedef enum logic {FILL, HOLD} state_t;

  state_t                          state;
  logic [IW-1:0]                   idx;
  logic [LANES-1:0][LANE_W-1:0]    data_q;
  logic                            in_xfer;
  logic                            out_xfer;
  logic                            close;

  assign in_ready = (state == FILL) || out_ready;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign close    = in_last || (idx == IW'(LANES-1));
  assign out_data = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      idx       <= '0;
      data_q    <= '0;
      out_mask  <= '0;
      out_count <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        FILL: begin
          if (in_xfer) begin
            data_q[idx]   <= in_data;
            out_mask[idx] <= 1'b1;
            out_count     <= CW'(idx) + CW'(1);
            if (close) begin
              state     <= HOLD;
              out_valid <= 1'b1;
              idx       <= '0;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        HOLD: begin
          if (out_xfer) begin
            if (in_xfer) begin
              // zero-bubble bypass: new element opens the next word
              data_q    <= DW'(in_data);
              out_mask  <= LANES'(1);
              out_count <= CW'(1);
              if (in_last) begin
                idx <= '0;
              end else begin
                state     <= FILL;
                out_valid <= 1'b0;
                idx       <= IW'(1);
              end
            end else begin
              data_q    <= '0;
              out_mask  <= '0;
              out_count <= '0;
              state     <= FILL;
              out_valid <= 1'b0;
              idx       <= '0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/packed_lane_packer.md
Name: packed_lane_packer

Overview:
- Write-side counterpart to packed-array element selection: assembles a stream of LANE_W-bit elements into a two-dimensional packed word, logic [LANES-1:0][LANE_W-1:0].
- Element k of a word lands in lane k, i.e. out_data[k], which occupies bits [k*LANE_W +: LANE_W].
- Sits between a narrow element source and a wide word consumer.
- Valid/ready handshakes on both sides.

Parameters:
- LANES, 4, number of packed lanes per word; legal range ≥2.
- LANE_W, 8, bits per lane; legal range ≥1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input element valid
- in_ready  output  1  packer can accept an element this cycle
- in_data  input  LANE_W  element value
- in_last  input  1  element closes the current word (partial flush)
- out_valid  output  1  assembled word available
- out_ready  input  1  consumer accepts word
- out_data  output  LANES*LANE_W  packed word, viewed as [LANES-1:0][LANE_W-1:0]
- out_mask  output  LANES  bit k set iff lane k was written
- out_count  output  $clog2(LANES+1)  number of lanes written (1..LANES)

Behaviour:
- Reset (async, rst_n=0): state FILL, lane index 0, out_valid=0, out_data=0, out_mask=0, out_count=0, in_ready=1 once rst_n is deasserted.
- Transfer definitions:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- States:
  - FILL: accumulating; out_valid=0; in_ready=1.
  - HOLD: word presented; out_valid=1; in_ready=out_ready.
- FILL, input transfer at lane index i:
  - Write lane i, set mask bit i, count=i+1.
  - If i==LANES-1 or in_last: go to HOLD next cycle and reset the index to 0.
  - Otherwise: index i+1.
  - Only the addressed lane changes.
  - Unwritten lanes of a word read as 0.
- HOLD:
  - out_data, out_mask and out_count are stable until the output transfer.
  - Output transfer with no input transfer: clear data, mask and count to 0; go to FILL.
- HOLD with an input transfer in the same cycle (bypass, zero bubble):
  - The new element starts the next word in lane 0, and the previous lanes are cleared.
  - If in_last or LANES==1 is not possible (LANES≥2), in_last forces an immediate return to HOLD with count=1.
  - Otherwise the next state is FILL with index 1.
- Latency:
  - A word becomes valid the cycle after the input transfer that completed it.
  - Full-rate throughput is one element per cycle with out_ready held high.
- Wrap-around: the lane index wraps LANES-1 → 0 only through the HOLD path; it never exceeds LANES-1.
- in_last on the lane LANES-1 element is identical to a full word: mask all ones, count=LANES.
- in_data and in_last are ignored when in_valid=0. in_valid without in_ready holds no state.
- Reset mid-word or mid-HOLD discards partial and pending data immediately. out_valid drops asynchronously.
- All outputs are registered. in_ready is combinational from state and out_ready only.

Test Plan:
- Full word: feed 0x11,0x22,0x33,0x44 on consecutive cycles, out_ready=1 → one cycle later out_data=0x44332211, out_data[2]=0x33, out_mask=4'b1111, out_count=4.
- Partial flush: feed 0xAA, then 0xBB with in_last, out_ready=1 → out_data=0x0000BBAA, out_mask=4'b0011, out_count=2. The next word starts at lane 0.
- Backpressure: complete word 0x04030201, hold out_ready=0 for 5 cycles, drive in_valid=1 with 0x55 → in_ready=0 and out_data stable throughout. When out_ready rises, 0x55 is accepted in the same cycle, and the next word's lane 0 = 0x55 with bits [31:8]=0.
- Streaming: 12 elements 0x00..0x0B back-to-back with out_ready=1 → three words 0x03020100, 0x07060504, 0x0B0A0908 on consecutive 4-cycle boundaries, with no input stall.
- Single-element word: in_last on the first element 0x7F → out_data=0x0000007F, out_mask=4'b0001, out_count=1.
- Async reset: assert rst_n=0 after two lanes are written, mid-cycle → out_valid, out_mask and out_count are 0 immediately. After release, feeding 0x10,0x20,0x30,0x40 yields 0x40302010, with no stale lanes.
